// File: rtl/magic_nmi_if.sv
// CPU-side bus bundle seen by the magic NMI sequencer: address/data/control
// from the Z80, INT from the clock generator, and the NMI line back to the CPU.
interface magic_nmi_if;
  logic [15:0] a;
  logic [7:0]  d;
  logic        m1;
  logic        mreq;
  logic        rd;
  logic        rfsh;
  logic        n_int;
  logic        n_nmi;

  modport master (output a, d, m1, mreq, rd, rfsh, n_int, input n_nmi);
  modport slave  (input a, d, m1, mreq, rd, rfsh, n_int, output n_nmi);
endinterface

// File: rtl/magic_nmi.sv
// Magic-button NMI sequencer: debounces the button, raises NMI outside INT and
// keeps the service ROM mapped from the 0x0066 fetch until the handler's RETN.
module magic_nmi #(
  parameter int DEBOUNCE    = 16,
  parameter int NMI_TIMEOUT = 255
) (
  input  logic        rst_n,
  input  logic        clkcpu,
  input  logic        magic_button,
  magic_nmi_if.slave  cpu,
  output logic        magic_map,
  output logic        magic_active
);

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int TOW = $clog2(NMI_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE);
  localparam logic [TOW-1:0] TO_MAX = TOW'(NMI_TIMEOUT);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ARMED      = 3'd1;
  localparam logic [2:0] S_NMI_ASSERT = 3'd2;
  localparam logic [2:0] S_MAPPED     = 3'd3;
  localparam logic [2:0] S_UNMAP_PEND = 3'd4;

  logic           r_btn_meta;
  logic           r_btn_s;
  logic [DBW-1:0] r_db_cnt;
  logic [7:0]     r_op;
  logic           r_m1;
  logic           r_ed_flag;
  logic [2:0]     r_state;
  logic [TOW-1:0] r_to_cnt;
  logic           r_re_armed;
  logic           r_n_nmi;

  logic           w_db_change;
  logic           w_pressed;
  logic           w_released;
  logic           w_fetch;
  logic           w_m1_end;
  logic           w_m1_rise;
  logic           w_retn;
  logic           w_nmi_fetch;
  logic [TOW-1:0] w_to_next;
  logic           w_timeout;
  logic           w_map_r;
  logic           w_early_map;
  logic           w_early_unmap;

  // Counter measures how long btn_s has held its current level.
  assign w_db_change = r_btn_meta ^ r_btn_s;
  assign w_pressed   = (r_db_cnt == DB_MAX) &  r_btn_s;
  assign w_released  = (r_db_cnt == DB_MAX) & ~r_btn_s;

  assign w_fetch     = cpu.m1 & cpu.mreq & cpu.rd & ~cpu.rfsh;
  assign w_m1_end    = r_m1 & ~cpu.m1;
  assign w_m1_rise   = cpu.m1 & ~r_m1;
  assign w_retn      = r_ed_flag & (r_op[7:6] == 2'b01) & (r_op[2:0] == 3'b101)
                     & (r_op != 8'h4D);
  assign w_nmi_fetch = w_fetch & (cpu.a == 16'h0066);

  assign w_to_next   = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
  assign w_timeout   = (w_to_next == TO_MAX);

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_btn_meta <= magic_button;
      r_btn_s    <= r_btn_meta;
      if (w_db_change)
        r_db_cnt <= '0;
      else if (r_db_cnt != DB_MAX)
        r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // RETN check uses the ed_flag from the previous opcode, so it is updated after.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= 8'h00;
      r_m1      <= 1'b0;
      r_ed_flag <= 1'b0;
    end else begin
      r_m1 <= cpu.m1;
      if (w_fetch)
        r_op <= cpu.d;
      if (w_m1_end)
        r_ed_flag <= (r_op == 8'hED);
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      r_re_armed <= 1'b1;
    end else if ((r_state == S_IDLE) && w_pressed && r_re_armed) begin
      r_re_armed <= 1'b0;
    end else if (w_released) begin
      r_re_armed <= 1'b1;
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
      r_n_nmi  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_n_nmi <= 1'b1;
          if (w_pressed && r_re_armed)
            r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (cpu.n_int) begin
            r_n_nmi  <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= S_NMI_ASSERT;
          end
        end
        S_NMI_ASSERT: begin
          r_to_cnt <= w_to_next;
          // A fetch landing on the timeout edge still counts as taken.
          if (w_nmi_fetch) begin
            r_n_nmi <= 1'b1;
            r_state <= S_MAPPED;
          end else if (w_timeout) begin
            r_n_nmi <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_MAPPED: begin
          if (w_m1_end && w_retn)
            r_state <= S_UNMAP_PEND;
        end
        S_UNMAP_PEND: begin
          if (w_m1_rise)
            r_state <= S_IDLE;
        end
        default: begin
          r_n_nmi <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_map_r       = (r_state == S_MAPPED) | (r_state == S_UNMAP_PEND);
  assign w_early_map   = (r_state == S_NMI_ASSERT) & cpu.m1 & cpu.mreq & (cpu.a == 16'h0066);
  assign w_early_unmap = (r_state == S_UNMAP_PEND) & cpu.m1;

  assign magic_map    = (w_map_r | w_early_map) & ~w_early_unmap;
  assign magic_active = (r_state != S_IDLE);
  assign cpu.n_nmi    = r_n_nmi;

endmodule

// File: tb/tb_magic_nmi.sv
// Randomised bench for magic_nmi: stimulus predicts output-change events into a
// queue, a monitor pops and compares them whenever the outputs change.
module tb_magic_nmi;

  logic clkcpu;
  logic rst_n;
  logic magic_button;
  logic magic_map;
  logic magic_active;

  magic_nmi_if bus();

  magic_nmi #(.DEBOUNCE(16), .NMI_TIMEOUT(255)) dut (
    .rst_n        (rst_n),
    .clkcpu       (clkcpu),
    .magic_button (magic_button),
    .cpu          (bus),
    .magic_map    (magic_map),
    .magic_active (magic_active)
  );

  initial clkcpu = 1'b0;
  always #5 clkcpu = ~clkcpu;

  int cyc = 0;
  always @(posedge clkcpu) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic n_nmi;
    logic map;
    logic act;
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] pool     [10] = '{8'hED, 8'h45, 8'h4D, 8'hDD, 8'h00, 8'h55, 8'h7D, 8'hED, 8'hCB, 8'h6D};
  logic [7:0] retn_tab [7]  = '{8'h45, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D};
  logic [7:0] dir_ops[$];

  event btn_go;
  event nint_go;
  int   btn_hold;
  int   nint_len;

  function automatic void push_ev(int c, logic n, logic m, logic a);
    ev_t e;
    e.cyc = c; e.n_nmi = n; e.map = m; e.act = a;
    exp_q.push_back(e);
  endfunction

  // RETN is ED followed by any of these opcode bytes (RETI 4D excluded).
  function automatic bit is_retn(logic [7:0] b);
    for (int i = 0; i < 7; i++)
      if (retn_tab[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic l_n, l_m, l_a;
    ev_t  e;
    l_n = 1'b1; l_m = 1'b0; l_a = 1'b0;
    @(negedge clkcpu);
    n_cmp++;
    if ({bus.n_nmi, magic_map, magic_active} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_state: got nmi=%b map=%b act=%b, required nmi=1 map=0 act=0",
               bus.n_nmi, magic_map, magic_active);
    end
    forever begin
      @(negedge clkcpu);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_event: no output change at cyc %0d, required nmi=%b map=%b act=%b",
                 e.cyc, e.n_nmi, e.map, e.act);
      end
      if ({bus.n_nmi, magic_map, magic_active} !== {l_n, l_m, l_a}) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: cyc %0d got nmi=%b map=%b act=%b, required no change",
                   cyc, bus.n_nmi, magic_map, magic_active);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || {bus.n_nmi, magic_map, magic_active} !== {e.n_nmi, e.map, e.act}) begin
            n_bad++;
            $display("FAIL event: got nmi=%b map=%b act=%b at cyc %0d, required nmi=%b map=%b act=%b at cyc %0d",
                     bus.n_nmi, magic_map, magic_active, cyc, e.n_nmi, e.map, e.act, e.cyc);
          end
        end
        l_n = bus.n_nmi; l_m = magic_map; l_a = magic_active;
      end
    end
  end

  // ---------------- background drivers ----------------
  initial begin
    magic_button = 1'b0;
    forever begin
      @(btn_go);
      magic_button = 1'b1;
      repeat (btn_hold) @(posedge clkcpu);
      #1 magic_button = 1'b0;
    end
  end

  initial begin
    bus.n_int = 1'b1;
    forever begin
      @(nint_go);
      bus.n_int = 1'b0;
      repeat (nint_len) @(posedge clkcpu);
      #1 bus.n_int = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: cyc %0d, required completion before cycle 50000", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clkcpu);
    #1;
  endtask

  task automatic bus_idle();
    bus.a = 16'h0000; bus.d = 8'hFF;
    bus.m1 = 1'b0; bus.mreq = 1'b0; bus.rd = 1'b0; bus.rfsh = 1'b0;
  endtask

  // Non-M1 memory traffic, sometimes at 0x0066, must never map or stop the NMI.
  task automatic bus_noise();
    bus.a    = ($urandom_range(0, 3) == 0) ? 16'h0066 : 16'($urandom);
    bus.d    = 8'($urandom);
    bus.m1   = 1'b0;
    bus.mreq = 1'($urandom);
    bus.rd   = 1'($urandom);
    bus.rfsh = 1'b0;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) begin
      bus_noise();
      tick();
    end
    bus_idle();
  endtask

  // Four-cycle opcode fetch: two M1 cycles then refresh, then idle.
  task automatic do_fetch(logic [15:0] addr, logic [7:0] op);
    bus.a = addr; bus.d = op;
    bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1; bus.rfsh = 1'b0;
    tick(); tick();
    bus.a = 16'h3F00; bus.m1 = 1'b0; bus.rd = 1'b0; bus.rfsh = 1'b1;
    tick();
    bus.mreq = 1'b0; bus.rfsh = 1'b0;
    tick();
  endtask

  task automatic nmi_scenario(int hold, int nint_low, int off, int nbody, bit tmo, logic [7:0] retn_b);
    int         p, e0, n, tend;
    logic [7:0] ops[$];
    logic [7:0] prev, b;
    logic [15:0] addr;
    bit         mapped, pend;
    p = cyc;
    $display("scenario nmi: cyc=%0d hold=%0d nint_low=%0d off=%0d nbody=%0d timeout=%0d",
             p, hold, nint_low, off, nbody, tmo);
    btn_hold = hold;
    ->btn_go;
    if (nint_low > 0) begin
      nint_len = nint_low;
      ->nint_go;
    end
    // Armed after sync + debounce; NMI on the first edge with INT inactive.
    e0 = p + 20;
    if (nint_low > 0 && p + nint_low + 1 > e0) e0 = p + nint_low + 1;
    push_ev(p + 19, 1'b1, 1'b0, 1'b1);
    push_ev(e0, 1'b0, 1'b0, 1'b1);
    if (tmo) begin
      push_ev(e0 + 255, 1'b1, 1'b0, 1'b0);
      wait_until(e0 + 260);
    end else begin
      wait_until(e0 + off);
      push_ev(cyc, 1'b0, 1'b1, 1'b1);
      push_ev(cyc + 1, 1'b1, 1'b1, 1'b1);
      do_fetch(16'h0066, 8'hF5);
      if (dir_ops.size() > 0) begin
        ops = dir_ops;
      end else begin
        for (int i = 0; i < nbody; i++) ops.push_back(pool[$urandom_range(0, 9)]);
      end
      ops.push_back(8'hED);
      ops.push_back(retn_b);
      n = ops.size();
      prev = 8'hF5; mapped = 1'b1; pend = 1'b0;
      for (int i = 0; i <= n; i++) begin
        if (i == n) begin
          addr = 16'h1234; b = 8'h00;
        end else begin
          addr = ($urandom_range(0, 5) == 0) ? 16'h0066 : 16'h0100 + 16'(i);
          b = ops[i];
        end
        if (pend) begin
          push_ev(cyc, 1'b1, 1'b0, 1'b1);
          push_ev(cyc + 1, 1'b1, 1'b0, 1'b0);
          pend = 1'b0; mapped = 1'b0;
        end
        do_fetch(addr, b);
        if (mapped && prev == 8'hED && is_retn(b)) pend = 1'b1;
        prev = b;
      end
    end
    tend = (cyc > p + hold) ? cyc : p + hold;
    wait_until(tend + 40);
  endtask

  task automatic reset_scenario(bit in_mapped, int r);
    int p, e0;
    p = cyc;
    $display("scenario reset: cyc=%0d in_mapped=%0d r=%0d", p, in_mapped, r);
    btn_hold = 20;
    ->btn_go;
    e0 = p + 20;
    push_ev(p + 19, 1'b1, 1'b0, 1'b1);
    push_ev(e0, 1'b0, 1'b0, 1'b1);
    wait_until(e0 + r);
    if (in_mapped) begin
      push_ev(cyc, 1'b0, 1'b1, 1'b1);
      push_ev(cyc + 1, 1'b1, 1'b1, 1'b1);
      do_fetch(16'h0066, 8'hF5);
      do_fetch(16'h0101, 8'hED);
    end
    push_ev(cyc, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.n_nmi, magic_map, magic_active} !== 3'b100) begin
      n_bad++;
      $display("FAIL async_reset: got nmi=%b map=%b act=%b, required nmi=1 map=0 act=0",
               bus.n_nmi, magic_map, magic_active);
    end
    tick(); tick();
    rst_n = 1'b1;
    wait_until(cyc + 40);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ev_t e;
    int  sel, hold, nl, off, nb;
    rst_n = 1'b0;
    bus_idle();
    repeat (3) tick();
    rst_n = 1'b1;
    wait_until(cyc + 30);

    nmi_scenario(40, 0, 30, 0, 1'b0, 8'h45);
    nmi_scenario(40, 32, 10, 2, 1'b0, 8'h7D);
    dir_ops = '{8'hED, 8'h4D, 8'hDD, 8'h45};
    nmi_scenario(30, 0, 20, 0, 1'b0, 8'h45);
    dir_ops.delete();
    nmi_scenario(400, 0, 0, 0, 1'b1, 8'h45);
    nmi_scenario(30, 0, 254, 1, 1'b0, 8'h55);
    reset_scenario(1'b0, 50);
    reset_scenario(1'b1, 5);

    $display("scenario glitch: cyc=%0d hold=10", cyc);
    btn_hold = 10;
    ->btn_go;
    wait_until(cyc + 60);

    for (int k = 0; k < 14; k++) begin
      sel  = int'($urandom_range(0, 7));
      hold = int'($urandom_range(20, 120));
      nl   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 45)) : 0;
      off  = int'($urandom_range(1, 200));
      nb   = int'($urandom_range(0, 6));
      if (sel == 0)
        nmi_scenario(hold, nl, 0, 0, 1'b1, 8'h45);
      else if (sel == 1)
        reset_scenario(1'($urandom), int'($urandom_range(2, 150)));
      else
        nmi_scenario(hold, nl, off, nb, 1'b0, retn_tab[$urandom_range(0, 6)]);
    end

    wait_until(cyc + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL leftover_event: cyc %0d never seen, required nmi=%b map=%b act=%b",
               e.cyc, e.n_nmi, e.map, e.act);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/magic_nmi.md
# magic_nmi

Magic-button NMI sequencer sitting beside the CPU clock/INT generator in the CPLD. It runs on the gated CPU clock and takes that generator's INT line as an input. It debounces the magic button, delivers a Z80 NMI only outside an active INT, and asserts `magic_map` from the fetch at 0x0066 until the handler's RETN completes. The memory mapper consumes `magic_map` to page in the service ROM.

## Interface
Parameters:
- `DEBOUNCE`, default 16: consecutive `clkcpu` cycles the synchronised button must be stable (pressed to arm, released to re-arm).
- `NMI_TIMEOUT`, default 255: maximum `clkcpu` cycles `n_nmi` stays low waiting for the 0x0066 fetch.

Ports:
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `clkcpu`, in, 1: clock; rising edge.
- `magic_button`, in, 1: raw button, active-high, asynchronous to `clkcpu`.
- `n_int`, in, 1: CPU INT line from the clock/INT generator; low = INT active.
- `a`, in, 16: CPU address bus.
- `d`, in, 8: CPU data bus, read direction.
- `m1`, in, 1: active-high M1.
- `mreq`, in, 1: active-high MREQ.
- `rd`, in, 1: active-high RD.
- `rfsh`, in, 1: active-high RFSH.
- `n_nmi`, out, 1: NMI to CPU, active-low, registered.
- `magic_map`, out, 1: service ROM mapped.
- `magic_active`, out, 1: high in any state other than IDLE.

## Operation
- Button path:
  - 2-flop synchroniser into `btn_s`.
  - Debounce counter of width `clog2(DEBOUNCE+1)` resets on any change of `btn_s`.
  - `pressed` is set after `DEBOUNCE` stable-high cycles.
  - `released` is set after `DEBOUNCE` stable-low cycles.
- Opcode capture:
  - `fetch = m1 & mreq & rd & ~rfsh`.
  - On every edge with `fetch` high, register `d` into `op_r`.
  - `m1_r` is `m1` delayed one edge. `m1_end = m1_r & ~m1`.
  - On `m1_end`, `op_r` is the completed opcode.
- Prefix tracking:
  - `ed_flag` is set on `m1_end` with `op_r`==0xED.
  - `ed_flag` is cleared on any other `m1_end`.
  - RETN decode: `ed_flag` set and `op_r` matches 01xxx101, excluding 0x4D (RETI).
- State machine:
  - IDLE: `n_nmi`=1. Go to ARMED on `pressed` & `re_armed`.
  - ARMED: wait for `n_int`=1 sampled. Then `n_nmi`<=0, clear the timeout counter, go to NMI_ASSERT.
  - NMI_ASSERT:
    - `n_nmi`=0; the timeout counter increments.
    - Fetch with `a`==16'h0066 while `m1` is high: `n_nmi`<=1, go to MAPPED.
    - Counter reaches `NMI_TIMEOUT`: `n_nmi`<=1, go to IDLE, `magic_map` never asserted.
  - MAPPED: `magic_map`=1. RETN decoded on `m1_end`: go to UNMAP_PEND.
  - UNMAP_PEND: `magic_map` stays 1. Next rising `m1` (`m1 & ~m1_r`): go to IDLE.
- `re_armed`:
  - Cleared on entry to ARMED.
  - Set when `released` is observed.
  - Reset value 1.
  - Holding the button through a whole NMI never causes a second NMI.
- `magic_map` output:
  - `map_r`, the registered MAPPED|UNMAP_PEND.
  - ORed with early map: NMI_ASSERT & `m1` & `mreq` & `a`==0x0066. This makes the 0x0066 fetch itself come from service ROM.
  - ANDed with NOT early unmap: UNMAP_PEND & `m1`. This makes the return-address fetch come from normal memory.
- Nested NMI:
  - The button is ignored in MAPPED and UNMAP_PEND.
  - A fetch of 0x0066 in MAPPED has no effect.

## Timing
- Reset values:
  - Outputs: `n_nmi`=1, `magic_map`=0, `magic_active`=0.
  - Internal: state IDLE, `ed_flag`=0, counters 0, `re_armed`=1.
- Reset mid-operation: asynchronously returns to IDLE and releases `n_nmi` immediately.
- Button press to `n_nmi` low: 2 sync + `DEBOUNCE` + 1 (ARMED) + 1 register edges, plus any wait for `n_int` high.
- `n_nmi` rises on the first edge after the 0x0066 fetch is seen.
- `magic_map` is combinationally valid in the same cycle `a`=0x0066 and `m1` appear.
- Unmap is combinational on the first `m1` after RETN.
- Simultaneous events:
  - `n_int` low and `pressed` in IDLE: enter ARMED, hold there.
  - Timeout and 0x0066 fetch on the same edge: the fetch wins (MAPPED).
  - ED at `m1_end` with a pending RETN check: the current `op_r` is evaluated before `ed_flag` is updated.
- Wrap-around: the debounce and timeout counters saturate and never wrap.

## Test plan
- Press held 40 cycles with `n_int`=1: `n_nmi` low 2+16+2 cycles after press. Fetch 0x0066 gives `magic_map`=1 in the same cycle and `n_nmi`=1 on the next edge.
- Press while `n_int`=0 for 32 cycles: `n_nmi` stays 1 until the edge after `n_int` rises, then goes low.
- In MAPPED, fetch ED then 45: `magic_map` holds 1. It drops when `m1` rises for the next fetch at 0x1234.
- In MAPPED, fetch ED 4D (RETI), then DD 45: `magic_map` stays 1.
- No 0x0066 fetch: `n_nmi` returns to 1 after exactly 255 cycles, `magic_map` never 1. Button still held gives no new NMI until released for 16 cycles and pressed again.
- `rst_n` pulsed low during NMI_ASSERT and during MAPPED: `n_nmi`=1 and `magic_map`=0 immediately, `magic_active`=0.
